// File: rtl/wb_uart_tx_if.sv
// Wishbone classic bus bundle for the UART transmitter.
// slave: cyc/stb/we/adr/dat_i in, dat_o/ack_o out; master is the mirror.
interface wb_uart_tx_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i,
        output dat_o, ack_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o
    );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave UART transmitter: byte FIFO + 8N1 serializer.
// Ports: clk_i, rst_i (async, high), wb (slave bus), tx_o (serial, idle high).
module wb_uart_tx #(
    parameter int CLK_DIV    = 1085,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_uart_tx_if.slave  wb,
    output logic         tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ack;
    logic [15:0] r_dat;
    logic        r_ovr;
    logic [15:0] r_div;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic [15:0] r_cnt;
    logic [7:0]  r_sh;
    logic [2:0]  r_idx;
    logic        r_tx;

    logic        w_req;
    logic        w_data_wr;
    logic        w_push;
    logic        w_drop;
    logic        w_stat_rd;
    logic        w_div_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic [15:0] w_rdata;
    logic [15:0] w_div_eff;
    logic        w_bit_end;
    logic        w_pop;
    logic        w_load;
    logic        w_shift;
    logic        w_tx_d;

    // ---- bus decode ----
    assign w_req     = wb.cyc_i & wb.stb_i & ~r_ack;
    assign w_data_wr = w_req & wb.we_i & (wb.adr_i == 2'd0);
    assign w_push    = w_data_wr & ~w_full;
    assign w_drop    = w_data_wr & w_full;
    assign w_stat_rd = w_req & ~wb.we_i & (wb.adr_i == 2'd1);
    assign w_div_wr  = w_req & wb.we_i & (wb.adr_i == 2'd2);

    // ---- FIFO flags: pointers carry one extra wrap bit ----
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_busy  = (r_state != S_IDLE);

    always_comb begin
        w_rdata = '0;
        case (wb.adr_i)
            2'd1:    w_rdata = {12'd0, r_ovr, w_busy, w_empty, w_full};
            2'd2:    w_rdata = r_div;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_ovr <= 1'b0;
            r_div <= 16'(CLK_DIV);
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wb.we_i) ? w_rdata : 16'd0;
            // a drop in the same cycle as the clearing read wins
            if (w_drop)
                r_ovr <= 1'b1;
            else if (w_stat_rd)
                r_ovr <= 1'b0;
            if (w_div_wr)
                r_div <= wb.dat_i;
        end
    end

    assign wb.ack_o = r_ack;
    assign wb.dat_o = r_dat;

    // ---- FIFO storage and pointers ----
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= wb.dat_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    // ---- bit timer: divisor 0/1 both mean one clock per bit ----
    assign w_div_eff = (r_div < 16'd2) ? 16'd1 : r_div;
    assign w_bit_end = (r_cnt == 16'd0);

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_START;
            S_START: if (w_bit_end) w_next = S_DATA;
            S_DATA:  if (w_bit_end && r_idx == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_bit_end) w_next = w_empty ? S_IDLE : S_START;
            default: w_next = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_pop   = 1'b0;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_tx_d  = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_pop  = ~w_empty;
                w_load = ~w_empty;
            end
            S_START: begin
                w_tx_d = 1'b0;
                w_load = w_bit_end;
            end
            S_DATA: begin
                w_tx_d  = r_sh[0];
                w_load  = w_bit_end;
                w_shift = w_bit_end;
            end
            S_STOP: begin
                w_pop  = w_bit_end & ~w_empty;
                w_load = w_bit_end & ~w_empty;
            end
            default: w_tx_d = 1'b1;
        endcase
    end

    // ---- serializer datapath; tx_o lags the state by one flop ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_sh  <= '0;
            r_idx <= '0;
            r_tx  <= 1'b1;
        end else begin
            if (w_load)
                r_cnt <= w_div_eff - 16'd1;
            else if (r_cnt != 16'd0)
                r_cnt <= r_cnt - 16'd1;
            if (w_pop) begin
                r_sh  <= r_mem[r_rp[AW-1:0]];
                r_idx <= '0;
            end else if (w_shift) begin
                r_sh  <= r_sh >> 1;
                r_idx <= r_idx + 3'd1;
            end
            r_tx <= w_tx_d;
        end
    end

    assign tx_o = r_tx;
endmodule
